// File: rtl/cdb_arbiter.sv
// Common data bus arbiter.
// Each execution unit deposits completed results into a small private slot
// buffer. Every cycle the oldest buffered result is broadcast on the CDB. Age
// is measured from the ROB head, so tags that wrap past the top of the ROB
// still order correctly. A branch mispredict discards buffered results that
// are younger than the mispredicting branch.
module cdb_arbiter #(
  parameter int NUM_REQ    = 3,  // 0 = ALU, 1 = branch, 2 = LSU
  parameter int BUF_DEPTH  = 2,
  parameter int PREG_WIDTH = 7,
  parameter int ROB_WIDTH  = 4,
  localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int SLOT_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*PREG_WIDTH-1:0] i_req_prd,
  input  logic [NUM_REQ*ROB_WIDTH-1:0]  i_req_rob_tag,
  input  logic [NUM_REQ*32-1:0]         i_req_data,
  input  logic [ROB_WIDTH-1:0]          i_rob_head,
  output logic                          o_cdb_valid,
  output logic [PREG_WIDTH-1:0]         o_cdb_prd,
  output logic [ROB_WIDTH-1:0]          o_cdb_rob_tag,
  output logic [31:0]                   o_cdb_data,
  output logic [SRC_W-1:0]              o_cdb_src,
  input  logic                          branch_mispredict,
  input  logic [ROB_WIDTH-1:0]          mispredict_rob_tag
);

  // One buffered result.
  typedef struct packed {
    logic [PREG_WIDTH-1:0] prd;
    logic [ROB_WIDTH-1:0]  tag;
    logic [31:0]           data;
  } entry_t;

  // Distance of a tag from the ROB head; the subtraction wraps modulo the ROB
  // size, so a smaller result always means an older instruction.
  function automatic logic [ROB_WIDTH-1:0] age_of(input logic [ROB_WIDTH-1:0] tag,
                                                   input logic [ROB_WIDTH-1:0] head);
    return tag - head;
  endfunction

  logic [NUM_REQ-1:0][BUF_DEPTH-1:0] slot_valid;
  entry_t                            slot_entry [NUM_REQ][BUF_DEPTH];

  logic [NUM_REQ-1:0]  has_free;
  logic [SLOT_W-1:0]   free_slot [NUM_REQ];
  logic [NUM_REQ-1:0]  push;
  entry_t              in_entry  [NUM_REQ];

  logic                any_valid;
  logic                grant;
  logic [SRC_W-1:0]    win_req;
  logic [SLOT_W-1:0]   win_slot;
  logic [ROB_WIDTH-1:0] win_age;
  entry_t              win_entry;
  logic [ROB_WIDTH-1:0] flush_age;

  // Find the lowest-index free slot of every requester.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      has_free[i]  = 1'b0;
      free_slot[i] = '0;
      for (int j = BUF_DEPTH - 1; j >= 0; j--) begin
        if (!slot_valid[i][j]) begin
          has_free[i]  = 1'b1;
          free_slot[i] = SLOT_W'(j);
        end
      end
    end
  end

  // Ready depends only on slot occupancy and the flush pulse, never on the
  // incoming valid or this cycle's grant: a slot freed by a grant becomes
  // usable one cycle later.
  assign o_req_ready = has_free & {NUM_REQ{~branch_mispredict}};
  assign push        = i_req_valid & o_req_ready;

  // Unpack the flattened request buses into one entry per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      in_entry[i].prd  = i_req_prd[i*PREG_WIDTH +: PREG_WIDTH];
      in_entry[i].tag  = i_req_rob_tag[i*ROB_WIDTH +: ROB_WIDTH];
      in_entry[i].data = i_req_data[i*32 +: 32];
    end
  end

  // Pick the oldest valid slot across all requesters. The strict less-than
  // keeps the first candidate found on a tie, i.e. the lowest requester index
  // and then the lowest slot index.
  always_comb begin
    any_valid = 1'b0;
    win_req   = '0;
    win_slot  = '0;
    win_age   = '1;
    win_entry = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < BUF_DEPTH; j++) begin
        if (slot_valid[i][j] &&
            (!any_valid || age_of(slot_entry[i][j].tag, i_rob_head) < win_age)) begin
          any_valid = 1'b1;
          win_req   = SRC_W'(i);
          win_slot  = SLOT_W'(j);
          win_age   = age_of(slot_entry[i][j].tag, i_rob_head);
          win_entry = slot_entry[i][j];
        end
      end
    end
  end

  // No broadcast happens in a flush cycle; the winner simply stays buffered
  // (or is discarded by the flush if it is on the wrong path).
  assign grant     = any_valid && !branch_mispredict;
  assign flush_age = age_of(mispredict_rob_tag, i_rob_head);

  // Slot occupancy: flush kills younger-than-branch slots, otherwise the
  // granted slot empties and a pushed result claims the lowest free slot.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        for (int j = 0; j < BUF_DEPTH; j++) begin
          if (branch_mispredict) begin
            if (slot_valid[i][j] &&
                age_of(slot_entry[i][j].tag, i_rob_head) > flush_age) begin
              slot_valid[i][j] <= 1'b0;
            end
          end else begin
            if (grant && win_req == SRC_W'(i) && win_slot == SLOT_W'(j)) begin
              slot_valid[i][j] <= 1'b0;
            end
            if (push[i] && free_slot[i] == SLOT_W'(j)) begin
              slot_valid[i][j] <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Slot payload storage, written on push.
  // NOTE: the payload array is deliberately left out of reset; the valid bits
  // alone say whether a slot holds anything, so resetting the data would only
  // add reset fan-out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        slot_entry[i][free_slot[i]] <= in_entry[i];
      end
    end
  end

  // Registered CDB broadcast; the payload holds its last value when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_cdb_valid   <= 1'b0;
      o_cdb_prd     <= '0;
      o_cdb_rob_tag <= '0;
      o_cdb_data    <= '0;
      o_cdb_src     <= '0;
    end else begin
      o_cdb_valid <= grant;
      if (grant) begin
        o_cdb_prd     <= win_entry.prd;
        o_cdb_rob_tag <= win_entry.tag;
        o_cdb_data    <= win_entry.data;
        o_cdb_src     <= win_req;
      end
    end
  end

endmodule
